// File: rtl/power_seq_pkg.sv
// Shared command codes, state encodings and per-state rail decode for the SBIS power sequencer.
package power_seq_pkg;

    localparam logic [7:0] PSEQ_CMD_DOWN  = 8'h00;
    localparam logic [7:0] PSEQ_CMD_UP    = 8'h01;
    localparam logic [7:0] PSEQ_CMD_CLEAR = 8'h02;

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_UP_VCORE = 4'd1,
        ST_UP_VDIG  = 4'd2,
        ST_WAIT_PG  = 4'd3,
        ST_UP_FUNC  = 4'd4,
        ST_ON       = 4'd5,
        ST_DN_FUNC  = 4'd6,
        ST_DN_VDIG  = 4'd7,
        ST_DN_VCORE = 4'd8,
        ST_FAULT    = 4'd9
    } pseq_state_t;

    typedef struct packed {
        logic off_vcore;
        logic off_vdig;
        logic off_pr;
        logic functional;
        logic rst_fpga;
    } rail_ctrl_t;

    // Rail levels held while sitting in a given state; anything not enabled rests at its OFF value.
    function automatic rail_ctrl_t rails_for(pseq_state_t s);
        rail_ctrl_t r;
        r.off_vcore  = 1'b1;
        r.off_vdig   = 1'b1;
        r.off_pr     = 1'b1;
        r.functional = 1'b0;
        r.rst_fpga   = 1'b1;
        case (s)
            ST_UP_VCORE, ST_DN_VDIG: begin
                r.off_vcore = 1'b0;
            end
            ST_UP_VDIG, ST_WAIT_PG, ST_DN_FUNC: begin
                r.off_vcore = 1'b0;
                r.off_vdig  = 1'b0;
            end
            ST_UP_FUNC, ST_ON: begin
                r.off_vcore  = 1'b0;
                r.off_vdig   = 1'b0;
                r.off_pr     = 1'b0;
                r.functional = 1'b1;
                r.rst_fpga   = (s == ST_UP_FUNC);
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic is_stable(pseq_state_t s);
        return (s == ST_OFF) || (s == ST_ON) || (s == ST_FAULT);
    endfunction

    function automatic logic [7:0] status_byte(pseq_state_t s);
        return {(s == ST_FAULT), !is_stable(s), 2'b00, s};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous SBIS power-good flag.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/power_seq.sv
// Timed, ordered power-up/power-down of the SBIS rails with one-deep status reporting.
// Optional build macro POWER_SEQ_WATCHDOG_EN: loss of power-good while ON drops straight to FAULT.
module power_seq #(
    parameter int T_VCORE      = 32000,
    parameter int T_VDIG       = 32000,
    parameter int T_PG_TIMEOUT = 320000,
    parameter int T_RST        = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_ena,
    input  logic       sbis_power_on,
    output logic       off_vcore_fpga,
    output logic       off_vdigital_fpga,
    output logic       off_pr_digital_fpga,
    output logic       functional,
    output logic       rst_fpga,
    output logic       have_msg,
    output logic [7:0] len,
    output logic [7:0] out_data,
    input  logic       rdreq
);
    import power_seq_pkg::*;

    localparam int T_MAX_A = (T_VCORE > T_VDIG) ? T_VCORE : T_VDIG;
    localparam int T_MAX_B = (T_PG_TIMEOUT > T_RST) ? T_PG_TIMEOUT : T_RST;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = $clog2(T_MAX) + 1;

    pseq_state_t      state, next_state;
    rail_ctrl_t       rails_q;
    logic [CNT_W-1:0] cnt, load_val;
    logic             sync_pg, timer_done, wd_trip;
    logic             cmd_up, cmd_down, cmd_clear;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sbis_power_on),
        .q   (sync_pg)
    );

    assign cmd_up     = in_ena && (in_data == PSEQ_CMD_UP);
    assign cmd_down   = in_ena && (in_data == PSEQ_CMD_DOWN);
    assign cmd_clear  = in_ena && (in_data == PSEQ_CMD_CLEAR);
    assign timer_done = (cnt == '0);

`ifdef POWER_SEQ_WATCHDOG_EN
    logic wd_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_low <= 1'b0;
        end else begin
            wd_low <= (state == ST_ON) && !sync_pg;
        end
    end

    assign wd_trip = (state == ST_ON) && !sync_pg && wd_low;
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
        end else begin
            state <= next_state;
        end
    end

    // An expiring timer wins over a command arriving in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_OFF:      if (cmd_up) next_state = ST_UP_VCORE;
            ST_UP_VCORE: if (timer_done) next_state = ST_UP_VDIG;
                         else if (cmd_down) next_state = ST_DN_VCORE;
            ST_UP_VDIG:  if (timer_done) next_state = ST_WAIT_PG;
                         else if (cmd_down) next_state = ST_DN_VDIG;
            ST_WAIT_PG:  if (timer_done && !sync_pg) next_state = ST_FAULT;
                         else if (cmd_down) next_state = ST_DN_VDIG;
                         else if (sync_pg) next_state = ST_UP_FUNC;
            ST_UP_FUNC:  if (timer_done) next_state = ST_ON;
                         else if (cmd_down) next_state = ST_DN_FUNC;
            ST_ON:       if (cmd_down) next_state = ST_DN_FUNC;
                         else if (wd_trip) next_state = ST_FAULT;
            ST_DN_FUNC:  if (timer_done) next_state = ST_DN_VDIG;
            ST_DN_VDIG:  if (timer_done) next_state = ST_DN_VCORE;
            ST_DN_VCORE: if (timer_done) next_state = ST_OFF;
            ST_FAULT:    if (cmd_clear) next_state = ST_OFF;
            default:     next_state = ST_OFF;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (next_state)
            ST_UP_VCORE: load_val = CNT_W'(T_VCORE - 1);
            ST_UP_VDIG:  load_val = CNT_W'(T_VDIG - 1);
            ST_WAIT_PG:  load_val = CNT_W'(T_PG_TIMEOUT - 1);
            ST_UP_FUNC, ST_DN_FUNC, ST_DN_VDIG, ST_DN_VCORE:
                         load_val = CNT_W'(T_RST - 1);
            default:     load_val = '0;
        endcase
    end

    // Loading duration-1 on entry makes each wait last exactly its parameter in cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= load_val;
        end else if (!timer_done) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rails_q <= rails_for(ST_OFF);
        end else begin
            rails_q <= rails_for(next_state);
        end
    end

    assign off_vcore_fpga      = rails_q.off_vcore;
    assign off_vdigital_fpga   = rails_q.off_vdig;
    assign off_pr_digital_fpga = rails_q.off_pr;
    assign functional          = rails_q.functional;
    assign rst_fpga            = rails_q.rst_fpga;

    // A fresh status byte overwrites any unread one; a pop only clears the pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_msg <= 1'b0;
            out_data <= 8'h00;
        end else if ((next_state != state) && is_stable(next_state)) begin
            have_msg <= 1'b1;
            out_data <= status_byte(next_state);
        end else if (rdreq && have_msg) begin
            have_msg <= 1'b0;
        end
    end

    assign len = 8'd1;

endmodule

// File: tb/tb_power_seq.sv
// Directed self-checking bench for power_seq using shortened timing parameters.
module tb_power_seq;

    localparam int TV = 20;
    localparam int TD = 16;
    localparam int TP = 50;
    localparam int TR = 8;

    // {off_vcore, off_vdigital, off_pr_digital, functional, rst_fpga}
    localparam logic [4:0] R_OFF   = 5'b11101;
    localparam logic [4:0] R_VCORE = 5'b01101;
    localparam logic [4:0] R_VDIG  = 5'b00101;
    localparam logic [4:0] R_FUNC  = 5'b00011;
    localparam logic [4:0] R_ON    = 5'b00010;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_ena;
    logic       sbis_power_on;
    logic       off_vcore_fpga, off_vdigital_fpga, off_pr_digital_fpga;
    logic       functional, rst_fpga, have_msg, rdreq;
    logic [7:0] len, out_data;

    int checks   = 0;
    int failures = 0;

    power_seq #(
        .T_VCORE      (TV),
        .T_VDIG       (TD),
        .T_PG_TIMEOUT (TP),
        .T_RST        (TR)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_data             (in_data),
        .in_ena              (in_ena),
        .sbis_power_on       (sbis_power_on),
        .off_vcore_fpga      (off_vcore_fpga),
        .off_vdigital_fpga   (off_vdigital_fpga),
        .off_pr_digital_fpga (off_pr_digital_fpga),
        .functional          (functional),
        .rst_fpga            (rst_fpga),
        .have_msg            (have_msg),
        .len                 (len),
        .out_data            (out_data),
        .rdreq               (rdreq)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] rails();
        return {off_vcore_fpga, off_vdigital_fpga, off_pr_digital_fpga, functional, rst_fpga};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] c);
        in_data = c;
        in_ena  = 1'b1;
        tick();
        in_ena  = 1'b0;
        in_data = 8'h00;
    endtask

    task automatic pop();
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = 8'h00; in_ena = 1'b0; sbis_power_on = 1'b0; rdreq = 1'b0;
        tick(3);
        rst = 1'b0;
        tick();
        checks++; if (rails() !== R_OFF) begin failures++; $display("[TB] FAIL reset_rails: got %b expected %b", rails(), R_OFF); end
        checks++; if (have_msg !== 1'b0) begin failures++; $display("[TB] FAIL reset_have_msg: got %b expected 0", have_msg); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (len !== 8'd1) begin failures++; $display("[TB] FAIL len: got %0d expected 1", len); end
    endtask

    task automatic test_ignored_cmds();
        send(8'h00);
        send(8'h02);
        send(8'h55);
        in_data = 8'h01; in_ena = 1'b0;
        tick(2);
        in_data = 8'h00;
        checks++; if (rails() !== R_OFF) begin failures++; $display("[TB] FAIL ignored_rails: got %b expected %b", rails(), R_OFF); end
        checks++; if (have_msg !== 1'b0) begin failures++; $display("[TB] FAIL ignored_have_msg: got %b expected 0", have_msg); end
    endtask

    task automatic test_power_up();
        send(8'h01);
        checks++; if (rails() !== R_VCORE) begin failures++; $display("[TB] FAIL up_vcore_plus1: got %b expected %b", rails(), R_VCORE); end
        tick(TV - 1);
        checks++; if (rails() !== R_VCORE) begin failures++; $display("[TB] FAIL up_vdig_early: got %b expected %b", rails(), R_VCORE); end
        tick();
        checks++; if (rails() !== R_VDIG) begin failures++; $display("[TB] FAIL up_vdig: got %b expected %b", rails(), R_VDIG); end
        tick(TD);
        sbis_power_on = 1'b1;
        tick(2);
        checks++; if (rails() !== R_VDIG) begin failures++; $display("[TB] FAIL up_sync_latency: got %b expected %b", rails(), R_VDIG); end
        tick();
        checks++; if (rails() !== R_FUNC) begin failures++; $display("[TB] FAIL up_func: got %b expected %b", rails(), R_FUNC); end
        tick(TR - 1);
        checks++; if (rails() !== R_FUNC) begin failures++; $display("[TB] FAIL up_rst_hold: got %b expected %b", rails(), R_FUNC); end
        checks++; if (have_msg !== 1'b0) begin failures++; $display("[TB] FAIL up_msg_early: got %b expected 0", have_msg); end
        tick();
        checks++; if (rails() !== R_ON) begin failures++; $display("[TB] FAIL up_on: got %b expected %b", rails(), R_ON); end
        checks++; if (have_msg !== 1'b1 || out_data !== 8'h05) begin failures++; $display("[TB] FAIL up_status: got %b/%h expected 1/05", have_msg, out_data); end
        pop();
        checks++; if (have_msg !== 1'b0) begin failures++; $display("[TB] FAIL up_pop: got %b expected 0", have_msg); end
    endtask

    task automatic test_power_down();
        send(8'h00);
        checks++; if (rails() !== R_VDIG) begin failures++; $display("[TB] FAIL dn_func: got %b expected %b", rails(), R_VDIG); end
        tick(TR - 1);
        checks++; if (rails() !== R_VDIG) begin failures++; $display("[TB] FAIL dn_func_hold: got %b expected %b", rails(), R_VDIG); end
        tick();
        checks++; if (rails() !== R_VCORE) begin failures++; $display("[TB] FAIL dn_vdig: got %b expected %b", rails(), R_VCORE); end
        tick(TR);
        checks++; if (rails() !== R_OFF || have_msg !== 1'b0) begin failures++; $display("[TB] FAIL dn_vcore: got %b/%b expected %b/0", rails(), have_msg, R_OFF); end
        tick(TR - 1);
        checks++; if (have_msg !== 1'b0) begin failures++; $display("[TB] FAIL dn_msg_early: got %b expected 0", have_msg); end
        tick();
        checks++; if (have_msg !== 1'b1 || out_data !== 8'h00) begin failures++; $display("[TB] FAIL dn_status: got %b/%h expected 1/00", have_msg, out_data); end
        pop();
    endtask

    task automatic test_fault();
        sbis_power_on = 1'b0;
        tick(3);
        send(8'h01);
        tick(TV + TD + TP - 1);
        checks++; if (rails() !== R_VDIG || have_msg !== 1'b0) begin failures++; $display("[TB] FAIL pg_wait_edge: got %b/%b expected %b/0", rails(), have_msg, R_VDIG); end
        tick();
        checks++; if (rails() !== R_OFF) begin failures++; $display("[TB] FAIL fault_rails: got %b expected %b", rails(), R_OFF); end
        checks++; if (have_msg !== 1'b1 || out_data !== 8'h89) begin failures++; $display("[TB] FAIL fault_status: got %b/%h expected 1/89", have_msg, out_data); end
        send(8'h01);
        send(8'h00);
        tick(2);
        checks++; if (rails() !== R_OFF || out_data !== 8'h89) begin failures++; $display("[TB] FAIL fault_sticky: got %b/%h expected %b/89", rails(), out_data, R_OFF); end
        pop();
        checks++; if (have_msg !== 1'b0) begin failures++; $display("[TB] FAIL fault_pop: got %b expected 0", have_msg); end
        send(8'h02);
        checks++; if (have_msg !== 1'b1 || out_data !== 8'h00) begin failures++; $display("[TB] FAIL clear_status: got %b/%h expected 1/00", have_msg, out_data); end
        pop();
    endtask

    task automatic test_down_during_vdig();
        send(8'h01);
        tick(TV + 4);
        checks++; if (rails() !== R_VDIG) begin failures++; $display("[TB] FAIL dv_in_vdig: got %b expected %b", rails(), R_VDIG); end
        send(8'h00);
        checks++; if (rails() !== R_VCORE) begin failures++; $display("[TB] FAIL dv_dn_vdig: got %b expected %b", rails(), R_VCORE); end
        tick(TR - 1);
        checks++; if (rails() !== R_VCORE) begin failures++; $display("[TB] FAIL dv_hold: got %b expected %b", rails(), R_VCORE); end
        tick();
        checks++; if (rails() !== R_OFF) begin failures++; $display("[TB] FAIL dv_vcore_off: got %b expected %b", rails(), R_OFF); end
        tick(TR);
        checks++; if (have_msg !== 1'b1 || out_data !== 8'h00) begin failures++; $display("[TB] FAIL dv_status: got %b/%h expected 1/00", have_msg, out_data); end
    endtask

    task automatic test_reset_mid();
        send(8'h01);
        tick(TV + TD + 5);
        checks++; if (rails() !== R_VDIG || have_msg !== 1'b1) begin failures++; $display("[TB] FAIL rm_wait_pg: got %b/%b expected %b/1", rails(), have_msg, R_VDIG); end
        rst = 1'b1;
        tick();
        checks++; if (rails() !== R_OFF) begin failures++; $display("[TB] FAIL rm_rails: got %b expected %b", rails(), R_OFF); end
        checks++; if (have_msg !== 1'b0 || out_data !== 8'h00) begin failures++; $display("[TB] FAIL rm_msg: got %b/%h expected 0/00", have_msg, out_data); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic go_on();
        bit reached = 1'b0;
        sbis_power_on = 1'b1;
        send(8'h01);
        for (int i = 0; i < 300 && !reached; i++) begin
            if (rst_fpga === 1'b0) reached = 1'b1;
            else tick();
        end
        checks++; if (!reached) begin failures++; $display("[TB] FAIL reach_on: rst_fpga=%b expected 0 within 300 cycles", rst_fpga); end
        pop();
    endtask

    task automatic test_pg_loss();
        go_on();
        sbis_power_on = 1'b0;
        tick(3);
        sbis_power_on = 1'b1;
        checks++; if (rails() !== R_ON) begin failures++; $display("[TB] FAIL pgl_first_sample: got %b expected %b", rails(), R_ON); end
`ifdef POWER_SEQ_WATCHDOG_EN
        tick();
        checks++; if (rails() !== R_OFF) begin failures++; $display("[TB] FAIL wd_rails: got %b expected %b", rails(), R_OFF); end
        checks++; if (have_msg !== 1'b1 || out_data !== 8'h89) begin failures++; $display("[TB] FAIL wd_status: got %b/%h expected 1/89", have_msg, out_data); end
        tick(3);
        checks++; if (have_msg !== 1'b1) begin failures++; $display("[TB] FAIL wd_msg_held: got %b expected 1", have_msg); end
        pop();
        checks++; if (have_msg !== 1'b0) begin failures++; $display("[TB] FAIL wd_pop: got %b expected 0", have_msg); end
        send(8'h02);
`else
        tick(6);
        checks++; if (rails() !== R_ON || have_msg !== 1'b0) begin failures++; $display("[TB] FAIL nowd_stays_on: got %b/%b expected %b/0", rails(), have_msg, R_ON); end
        send(8'h00);
        tick(3 * TR);
        checks++; if (have_msg !== 1'b1 || out_data !== 8'h00) begin failures++; $display("[TB] FAIL nowd_down: got %b/%h expected 1/00", have_msg, out_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_ignored_cmds();
        test_power_up();
        test_power_down();
        test_fault();
        test_down_during_vdig();
        test_reset_mid();
        test_pg_loss();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
